display_scan: RTL and testbench
===============================

DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 SHALL have parameter DIV, default 1000: clk cycles per scan slot; legal range 2..65535.
REQ-002 SHALL have parameter BLANK, default 16: blanking cycles at the start of each slot; legal range 1..DIV-1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have port matrixData, input, 128 bits: pixel p = row*8+col; bit [2p+1] = red, bit [2p] = green; 1 = lit.
REQ-006 SHALL have port numbersData, input, 32 bits: digit i = [4i+3:4i]; codes 0-E = hex glyphs 0-9,A,b,C,d,E; code F = blank.
REQ-007 SHALL have port row, output, 8 bits: matrix row select, active-high, one-hot or zero.
REQ-008 SHALL have ports colR and colG, output, 8 bits each: matrix column drive, active-low; bit c = column c.
REQ-009 SHALL have port seg, output, 8 bits: {dp,g,f,e,d,c,b,a}, active-high; dp always 0.
REQ-010 SHALL have port digSel, output, 8 bits: digit select, active-low, one-hot-zero; bit i = digit i.
REQ-011 SHALL have port frameStart, output, 1 bit: one-cycle pulse marking a snapshot load.

Function
REQ-012 SHALL keep prescaler cnt counting 0..DIV-1 and wrapping to 0; slot (3 bits) SHALL increment when cnt==DIV-1, wrapping 7->0.
REQ-013 SHALL define the load cycle as any cycle with cnt==0 and slot==0, including the first cycle after rst deasserts.
REQ-014 SHALL capture matrixData and numbersData into snapshot registers at the clock edge ending a load cycle; input changes at any other time SHALL NOT affect the display until the next load.
REQ-015 SHALL register frameStart=1 for exactly the cycle after each load cycle, and 0 otherwise.
REQ-016 SHALL register all display outputs, with output values in cycle k+1 derived from the cnt, slot, and snapshot values of cycle k.
REQ-017 SHALL blank the display when state cnt<BLANK: row=0, colR=colG=FF, seg=0, digSel=FF.
REQ-018 SHALL drive the active display when state cnt>=BLANK with slot s: row=1<<s; colR[c]=~snapR[s*8+c]; colG[c]=~snapG[s*8+c]; digSel=~(1<<s); seg=glyph(snapNum digit s).
REQ-019 SHALL use glyph segment values (a=bit0): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=00.
REQ-020 SHALL scan matrix row s and digit s in the same slot; frame period = 8*DIV cycles; duty per row = (DIV-BLANK)/(8*DIV).
REQ-021 SHALL never assert more than one bit of row or more than one low bit of digSel in any cycle, including at slot transitions.
REQ-022 SHALL NOT delay or reset the scan in response to input changes, and SHALL provide no handshake.

Reset
REQ-023 SHALL, while rst=1 at a clock edge, set cnt=0, slot=0, snapshot matrix=0, snapshot numbers=FFFFFFFF, row=0, colR=colG=FF, seg=0, digSel=FF, and frameStart=0.
REQ-024 SHALL, when rst is asserted mid-frame, apply REQ-023 at the next edge, discard the partial frame, and restart scanning at slot 0 with a fresh load.

Verification (DIV=4, BLANK=1)
REQ-025 SHALL cover: rst held 3 cycles then released, matrixData all 0, numbersData=FFFFFFFF -> all outputs at reset values; frameStart=1 in the 2nd cycle after release; display remains dark.
REQ-026 SHALL cover: matrixData = {64{2'b10}} (all red), numbersData = 88888888 -> each slot shows cycle 1 blank then 3 active cycles with row=1<<s, colR=00, colG=FF, seg=7F, digSel=~(1<<s); period 32 cycles.
REQ-027 SHALL cover: numbersData = 76543210 -> slot 0 seg=3F, slot 3 seg=4F, slot 7 seg=07; digit F -> seg=00 with digSel still selecting.
REQ-028 SHALL cover: matrixData changed while slot=3 -> rows 3-7 of the current frame are unchanged; the new data appears from slot 0 of the next frame, coincident with the frameStart pulse.
REQ-029 SHALL cover: rst asserted for 1 cycle at slot 5, cnt 2 -> next cycle all outputs at reset values; scan restarts at slot 0; frameStart pulses again.
REQ-030 SHALL cover: every cycle over 3 frames, checked by assertion -> row is zero or one-hot, ~digSel is zero or one-hot, and row/digSel are inactive whenever cnt<BLANK.

Source files
------------

// File: rtl/display_scan.sv
// Time-multiplexed driver for an 8x8 red/green LED matrix and an 8-digit 7-segment display.
// Inputs are snapshotted once per frame; every output is registered and blanked at the start of each slot.
module display_scan #(
   parameter int DIV   = 1000,
   parameter int BLANK = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] matrixData,
   input  logic [31:0]  numbersData,
   output logic [7:0]   row,
   output logic [7:0]   colR,
   output logic [7:0]   colG,
   output logic [7:0]   seg,
   output logic [7:0]   digSel,
   output logic         frameStart
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0]  cnt;
   logic [2:0]     slot;
   logic [127:0]   snapMat;
   logic [31:0]    snapNum;
   logic           load;
   logic [3:0]     dig;
   logic [7:0]     rowN, colRN, colGN, segN, digN;

   assign load = (cnt == '0) && (slot == '0);

   always_comb begin
      dig   = snapNum[{slot, 2'b00} +: 4];
      rowN  = '0;
      colRN = '1;
      colGN = '1;
      segN  = '0;
      digN  = '1;
      if (cnt >= CW'(BLANK)) begin
         rowN = 8'(1) << slot;
         digN = ~rowN;
         // pixel p = slot*8+c occupies bits {p,1} (red) and {p,0} (green)
         for (int c = 0; c < 8; c++) begin
            colRN[c] = ~snapMat[{slot, 3'(c), 1'b1}];
            colGN[c] = ~snapMat[{slot, 3'(c), 1'b0}];
         end
         case (dig)
            4'h0:    segN = 8'h3F;
            4'h1:    segN = 8'h06;
            4'h2:    segN = 8'h5B;
            4'h3:    segN = 8'h4F;
            4'h4:    segN = 8'h66;
            4'h5:    segN = 8'h6D;
            4'h6:    segN = 8'h7D;
            4'h7:    segN = 8'h07;
            4'h8:    segN = 8'h7F;
            4'h9:    segN = 8'h6F;
            4'hA:    segN = 8'h77;
            4'hB:    segN = 8'h7C;
            4'hC:    segN = 8'h39;
            4'hD:    segN = 8'h5E;
            4'hE:    segN = 8'h79;
            default: segN = 8'h00;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         slot       <= '0;
         snapMat    <= '0;
         snapNum    <= '1;
         row        <= '0;
         colR       <= '1;
         colG       <= '1;
         seg        <= '0;
         digSel     <= '1;
         frameStart <= 1'b0;
      end else begin
         if (cnt == CW'(DIV - 1)) begin
            cnt  <= '0;
            slot <= slot + 3'd1;
         end else begin
            cnt <= cnt + CW'(1);
         end
         if (load) begin
            snapMat <= matrixData;
            snapNum <= numbersData;
         end
         row        <= rowN;
         colR       <= colRN;
         colG       <= colGN;
         seg        <= segN;
         digSel     <= digN;
         frameStart <= load;
      end
   end

endmodule

// File: tb/tb_display_scan.sv
// Directed and randomized checks of display_scan against a cycle-count based reference model.
module tb_display_scan;
   localparam int DIV   = 4;
   localparam int BLANK = 1;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [127:0] matrixData = '0;
   logic [31:0]  numbersData = '1;
   logic [7:0]   row, colR, colG, seg, digSel;
   logic         frameStart;

   int checks = 0;
   int errors = 0;

   display_scan #(.DIV(DIV), .BLANK(BLANK)) dut (
      .clk(clk), .rst(rst), .matrixData(matrixData), .numbersData(numbersData),
      .row(row), .colR(colR), .colG(colG), .seg(seg), .digSel(digSel),
      .frameStart(frameStart)
   );

   always #5 clk = ~clk;

   logic [7:0] glyph [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                              8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h00};

   // model: n = cycles since reset released; the frame position follows from n alone
   int           n = 0;
   logic [127:0] sm = '0;
   logic [31:0]  sn = '1;
   logic [7:0]   erow, ecolR, ecolG, eseg, edig;
   logic         efs, eblank;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic r);
      int c, s;
      rst = r;
      erow = 8'h00; ecolR = 8'hFF; ecolG = 8'hFF; eseg = 8'h00; edig = 8'hFF;
      efs = 1'b0; eblank = 1'b1;
      if (r) begin
         n = 0; sm = '0; sn = '1;
      end else begin
         c = n % DIV;
         s = (n / DIV) % 8;
         efs = (c == 0) && (s == 0);
         if (c >= BLANK) begin
            eblank = 1'b0;
            erow = 8'(1 << s);
            edig = ~erow;
            for (int cc = 0; cc < 8; cc++) begin
               ecolR[cc] = ~sm[2 * (s * 8 + cc) + 1];
               ecolG[cc] = ~sm[2 * (s * 8 + cc)];
            end
            eseg = glyph[sn[4 * s +: 4]];
         end
         if (efs) begin
            sm = matrixData;
            sn = numbersData;
         end
         n++;
      end
      @(posedge clk);
      #1;
      chk("row", 32'(row), 32'(erow));
      chk("colR", 32'(colR), 32'(ecolR));
      chk("colG", 32'(colG), 32'(ecolG));
      chk("seg", 32'(seg), 32'(eseg));
      chk("digSel", 32'(digSel), 32'(edig));
      chk("frameStart", 32'(frameStart), 32'(efs));
      chk("row_onehot0", 32'($onehot0(row)), 32'd1);
      chk("dig_onehot0", 32'($onehot0(~digSel)), 32'd1);
      if (eblank) chk("blank_dark", {16'h0, row, digSel}, {16'h0, 8'h00, 8'hFF});
   endtask

   initial begin
      // reset held 3 cycles, dark inputs
      repeat (3) cyc(1'b1);
      repeat (40) cyc(1'b0);

      // all red, digit 8 everywhere
      matrixData  = {64{2'b10}};
      numbersData = 32'h8888_8888;
      repeat (64) cyc(1'b0);

      // ascending digits, then alternating blank digits
      numbersData = 32'h7654_3210;
      repeat (64) cyc(1'b0);
      numbersData = 32'h0F0F_0F0F;
      repeat (40) cyc(1'b0);

      // change matrix mid-frame at slot 3
      while ((n % 32) != 12) cyc(1'b0);
      matrixData = {$urandom, $urandom, $urandom, $urandom};
      numbersData = $urandom;
      repeat (64) cyc(1'b0);

      // reset pulse at slot 5, cnt 2
      while ((n % 32) != 22) cyc(1'b0);
      cyc(1'b1);
      repeat (40) cyc(1'b0);

      // random inputs changing at arbitrary times, occasional resets
      repeat (500) begin
         if ($urandom_range(0, 5) == 0) matrixData = {$urandom, $urandom, $urandom, $urandom};
         if ($urandom_range(0, 5) == 0) numbersData = $urandom;
         if ($urandom_range(0, 99) == 0) cyc(1'b1);
         else cyc(1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
